// File: rtl/imem_fetch_unit.sv
// Instruction fetch from a small programmable word memory: registered 1-cycle response,
// misaligned/out-of-range fault reporting, stall-and-hold backpressure, consumed-response counter.
module imem_fetch_unit #(
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   input  logic [AW-1:0] req_addr,
   output logic          req_ready,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_inst,
   output logic [1:0]    rsp_fault,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   output logic [15:0]   fetch_count
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [AW-1:0] LIMIT = AW'(4 * DEPTH);
   localparam logic [1:0] F_OK  = 2'b00;
   localparam logic [1:0] F_MIS = 2'b01;
   localparam logic [1:0] F_OOR = 2'b10;

   function automatic logic [31:0] init_word(input int idx);
      case (idx)
         0:       return 32'h0022_1825;
         1:       return 32'h24A4_0015;
         2:       return 32'hACE6_0005;
         3:       return 32'h1128_0007;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Misalignment is tested first so it wins over out-of-range.
   function automatic logic [1:0] classify(input logic [AW-1:0] addr);
      if (addr[1:0] != 2'b00) return F_MIS;
      if (addr >= LIMIT)      return F_OOR;
      return F_OK;
   endfunction

   logic [31:0]   mem [DEPTH];
   logic [IW-1:0] req_idx;
   logic [IW-1:0] prog_idx;
   logic [1:0]    req_fault;
   logic          prog_hit;
   logic          accept;

   logic          vld_p1;
   logic [31:0]   inst_p1;
   logic [1:0]    fault_p1;
   logic [15:0]   count;

   assign req_idx   = req_addr[IW+1:2];
   assign prog_idx  = prog_addr[IW+1:2];
   assign req_fault = classify(req_addr);
   assign prog_hit  = prog_we && (classify(prog_addr) == F_OK);
   assign req_ready = !vld_p1 || rsp_ready;
   assign accept    = req_valid && req_ready;

   // Memory words are never touched by reset; the read below sees the pre-write word.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [31:0] word = init_word(i);
      always_ff @(posedge clk) begin
         if (prog_hit && prog_idx == IW'(i))
            word <= prog_data;
      end
      assign mem[i] = word;
   end

   // Stage p1: registered response, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         inst_p1  <= '0;
         fault_p1 <= F_OK;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         fault_p1 <= req_fault;
         inst_p1  <= (req_fault == F_OK) ? mem[req_idx] : 32'h0000_0000;
      end else if (rsp_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (vld_p1 && rsp_ready)
         count <= count + 16'd1;
   end

   assign rsp_valid   = vld_p1;
   assign rsp_inst    = inst_p1;
   assign rsp_fault   = fault_p1;
   assign fetch_count = count;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a word-level reference model predicts every response,
// handshake and counter value; a separate monitor compares responses as the DUT presents them.
module tb_imem_fetch_unit;
   localparam int DEPTH = 16;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_inst;
   logic [1:0]    rsp_fault;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;
   logic [15:0]   fetch_count;

   imem_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_inst(rsp_inst), .rsp_fault(rsp_fault),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [1:0]  fault;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] mmem [DEPTH];
   logic        m_init = 1'b0;
   logic        m_pend = 1'b0;
   logic        m_zero = 1'b0;
   logic [15:0] m_cnt  = 16'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: the pending response, counter and memory as plain variables.
   always @(negedge clk) begin
      logic acc;
      exp_t e;
      if (m_init) begin
         check("req_ready", {31'd0, req_ready}, {31'd0, (!m_pend || rsp_ready)});
         check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_pend});
         check("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
         if (m_zero) begin
            check("idle_inst", rsp_inst, 32'd0);
            check("idle_fault", {30'd0, rsp_fault}, 32'd0);
         end
      end
      acc = req_valid && (!m_pend || rsp_ready) && !reset;
      if (acc) begin
         if (req_addr % 4 != 0) begin
            e.fault = 2'b01; e.inst = 32'd0;
         end else if (req_addr >= 4 * DEPTH) begin
            e.fault = 2'b10; e.inst = 32'd0;
         end else begin
            e.fault = 2'b00; e.inst = mmem[req_addr / 4];
         end
         sb.push_back(e);
         m_zero = 1'b0;
      end
      if (reset) begin
         m_pend = 1'b0; m_cnt = 16'd0; m_zero = 1'b1; m_init = 1'b1;
      end else begin
         if (m_pend && rsp_ready) m_cnt = m_cnt + 16'd1;
         if (acc) m_pend = 1'b1;
         else if (rsp_ready) m_pend = 1'b0;
      end
      if (prog_we && prog_addr % 4 == 0 && prog_addr < 4 * DEPTH)
         mmem[prog_addr / 4] = prog_data;
   end

   // Monitor: compares every presented response (including stalled cycles) with the queue head.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp: got inst 0x%08h fault %0d, expected none", rsp_inst, rsp_fault);
         end else begin
            check("rsp_inst", rsp_inst, sb[0].inst);
            check("rsp_fault", {30'd0, rsp_fault}, {30'd0, sb[0].fault});
            if (rsp_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic drive(input logic rv, input logic [31:0] ra, input logic rr,
                        input logic pw = 1'b0, input logic [31:0] pa = 32'd0,
                        input logic [31:0] pd = 32'd0, input logic rst = 1'b0);
      req_valid = rv; req_addr = ra; rsp_ready = rr;
      prog_we = pw; prog_addr = pa; prog_data = pd; reset = rst;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5) return 32'(4 * $urandom_range(0, DEPTH - 1));
      if (k == 6) return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      if (k == 7) return 32'(4 * DEPTH + 4 * $urandom_range(0, 7));
      if (k == 8) return 32'hFFFF_FFFC;
      return $urandom;
   endfunction

   initial begin
      mmem[0] = 32'h0022_1825; mmem[1] = 32'h24A4_0015;
      mmem[2] = 32'hACE6_0005; mmem[3] = 32'h1128_0007;
      for (int i = 4; i < DEPTH; i++) mmem[i] = 32'd0;

      reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      check("reset_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_count", {16'd0, fetch_count}, 32'd0);

      // Initial program words on consecutive cycles
      drive(1, 0, 1); drive(1, 4, 1); drive(1, 8, 1); drive(1, 12, 1);
      drive(0, 0, 1);
      check("count_after_4", {16'd0, fetch_count}, 32'd4);

      // Fault responses
      drive(1, 6, 1);
      check("mis_fault", {30'd0, rsp_fault}, 32'd1);
      check("mis_inst", rsp_inst, 32'd0);
      drive(1, 4 * DEPTH, 1);
      check("oor_fault", {30'd0, rsp_fault}, 32'd2);
      check("oor_inst", rsp_inst, 32'd0);
      drive(0, 0, 1);

      // Backpressure: hold three cycles, then accept on release
      drive(1, 4, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 8, 0);
         check("stall_ready", {31'd0, req_ready}, 32'd0);
         check("stall_inst", rsp_inst, 32'h24A4_0015);
      end
      drive(1, 8, 1);
      check("release_inst", rsp_inst, 32'hACE6_0005);
      drive(0, 0, 1);

      // Write and fetch of the same word in one cycle returns the old word
      drive(1, 20, 1, 1, 20, 32'hDEAD_BEEF);
      check("raw_old", rsp_inst, 32'd0);
      drive(1, 20, 1);
      check("raw_new", rsp_inst, 32'hDEAD_BEEF);
      drive(0, 0, 1);

      // Reset with a stalled response pending
      drive(1, 20, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      check("rst_pend_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_pend_count", {16'd0, fetch_count}, 32'd0);
      drive(1, 20, 1);
      check("mem_kept", rsp_inst, 32'hDEAD_BEEF);
      drive(0, 0, 1);

      // Randomized traffic with program writes and occasional resets
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0), rand_addr(), $urandom,
               ($urandom_range(0, 39) == 0));

      // Counter wrap: exactly 65536 consumed fetches from zero
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 65536; i++) drive(1, rand_addr(), 1);
      drive(0, 0, 1);
      check("count_wrap", {16'd0, fetch_count}, 32'd0);

      drive(0, 0, 1); drive(0, 0, 1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit instruction words (power of two, at least 4).
REQ-002 The block SHALL have parameter AW, default 32, meaning the byte-address width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning a fetch request is present.
REQ-006 The block SHALL have port req_addr, input, AW bits, the fetch byte address.
REQ-007 The block SHALL have port req_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, meaning rsp_inst and rsp_fault are valid.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer takes the response this cycle.
REQ-010 The block SHALL have port rsp_inst, output, 32 bits, the fetched instruction word.
REQ-011 The block SHALL have port rsp_fault, output, 2 bits: 00 ok, 01 misaligned, 10 out of range.
REQ-012 The block SHALL have port prog_we, input, 1 bit, the program-load write enable.
REQ-013 The block SHALL have port prog_addr, input, AW bits, the program-load byte address.
REQ-014 The block SHALL have port prog_data, input, 32 bits, the program-load data.
REQ-015 The block SHALL have port fetch_count, output, 16 bits, the number of completed responses.

Function
REQ-016 Words 0-3 SHALL initialise to 0x00221825, 0x24A40015, 0xACE60005 and 0x11280007; all other words SHALL initialise to 0.
REQ-017 req_ready SHALL equal (!rsp_valid || rsp_ready), combinationally; no other combinational path to outputs SHALL exist.
REQ-018 A request SHALL be accepted on the cycle req_valid && req_ready && !reset; exactly one response SHALL follow, with rsp_valid high on the next cycle (1-cycle latency).
REQ-019 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-020 If req_addr[1:0] != 0, the response SHALL be rsp_fault=01 with rsp_inst=0; misaligned SHALL take priority over out of range.
REQ-021 If aligned and req_addr >= 4*DEPTH, the response SHALL be rsp_fault=10 with rsp_inst=0 (NOP); the index SHALL NOT wrap.
REQ-022 Otherwise the response SHALL be rsp_fault=00 with rsp_inst equal to the indexed word.
REQ-023 While rsp_valid && !rsp_ready, rsp_inst, rsp_fault and rsp_valid SHALL hold stable; no request SHALL be accepted.
REQ-024 When rsp_ready is high and a new request is accepted in the same cycle, the new response SHALL replace the old one back-to-back, giving full throughput of one fetch per cycle.
REQ-025 When rsp_ready is high and no request is accepted, rsp_valid SHALL clear next cycle.
REQ-026 When prog_we is high and prog_addr is aligned and in range, the indexed word SHALL be written at the clock edge; other prog_we cycles SHALL be ignored silently.
REQ-027 On a program write and an accepted fetch to the same word in the same cycle, the response SHALL return the old (pre-write) word.
REQ-028 fetch_count SHALL increment by 1 on each cycle rsp_valid && rsp_ready, including faulted responses, wrapping 0xFFFF->0x0000.

Reset
REQ-029 While reset is high at a clock edge, rsp_valid SHALL become 0, rsp_inst 0, rsp_fault 00 and fetch_count 0.
REQ-030 Reset SHALL not alter memory contents; writes with prog_we during reset SHALL still take effect.
REQ-031 A request presented during a reset cycle SHALL be dropped; a pending unconsumed response SHALL be discarded.

Verification
REQ-032 Reset, then issue requests to addresses 0, 4, 8 and 12 with rsp_ready=1 -> 0x00221825, 0x24A40015, 0xACE60005 and 0x11280007 return on consecutive cycles with fault 00, and fetch_count reaches 4.
REQ-033 A request to address 6, then to 4*DEPTH -> fault 01 with inst 0, then fault 10 with inst 0.
REQ-034 Hold rsp_ready=0 for 3 cycles after fetching address 4 -> rsp stays 0x24A40015 and req_ready=0 throughout; release -> the next request is accepted in the same cycle.
REQ-035 prog_we writes 0xDEADBEEF to address 20 while fetching address 20 in the same cycle -> old value 0; the next fetch of address 20 -> 0xDEADBEEF.
REQ-036 Assert reset while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0 and fetch_count=0; fetching address 20 afterwards still returns 0xDEADBEEF.
REQ-037 Preload fetch_count near wrap by 65536 consumed fetches -> the counter reads 0x0000 again.
